// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer: state encoding and legal WIDTH bounds.
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

endpackage

// File: rtl/fa_bit.sv
// Combinational single-bit full adder built from gate primitives.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ab_x;
  logic ab_a;
  logic c_a;

  xor g_x0 (ab_x, a, b);
  xor g_x1 (sum, ab_x, cin);
  and g_a0 (ab_a, a, b);
  and g_a1 (c_a, ab_x, cin);
  or  g_o0 (cout, ab_a, c_a);

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: feeds one operand bit pair per cycle, LSB first, through a single fa_bit
// cell and presents a registered {cout, sum} with a one-cycle done pulse.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e          state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] sum_q;
  logic            carry_q;
  logic            cout_q;
  logic [CntW-1:0] cnt_q;

  logic fa_sum;
  logic fa_cout;

  fa_bit u_fa_bit (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StRun;
            a_sr_q  <= a;
            b_sr_q  <= b;
            carry_q <= cin;
            acc_q   <= '0;
            cnt_q   <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_sr_q  <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q  <= {1'b0, b_sr_q[WIDTH-1:1]};
          acc_q   <= {fa_sum, acc_q[WIDTH-1:1]};
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + CntW'(1);
          // Last bit: result registers take the accumulator including this edge's sum bit.
          if (cnt_q == CntLast) begin
            state_q <= StDone;
            sum_q   <= {fa_sum, acc_q[WIDTH-1:1]};
            cout_q  <= fa_cout;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Randomized self-checking bench for serial_add_seq (WIDTH=8) against an arithmetic model.
module tb_serial_add_seq;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks;
  int errors;

  serial_add_seq #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled and inputs changed 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Launch one operation and follow it to its done cycle (start dropped after acceptance).
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                       output logic [W-1:0] s, output logic c, output int lat,
                       output int bcnt, output bit timeout, output bit held);
    logic [W-1:0] s0;
    logic         c0;
    s0 = sum;
    c0 = cout;
    a = av;
    b = bv;
    cin = cv;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    lat = 0;
    bcnt = 0;
    timeout = 1'b1;
    held = 1'b1;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        s = sum;
        c = cout;
        timeout = 1'b0;
        break;
      end
      if (busy) bcnt++;
      if (sum !== s0 || cout !== c0) held = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0",
               busy, done, sum, cout);
    end
    start = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] s;
    logic c;
    int lat, bcnt;
    bit to, held;
    do_op(8'h5A, 8'h3C, 1'b0, s, c, lat, bcnt, to, held);
    checks++;
    if (to || s !== 8'h96 || c !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: sum=%h cout=%b timeout=%0d, required 96 0", s, c, to);
    end
    checks++;
    if (lat != W) begin
      errors++;
      $display("FAIL basic_latency: edges after accept=%0d, required %0d", lat, W);
    end
    checks++;
    if (bcnt != W) begin
      errors++;
      $display("FAIL basic_busy_cycles: %0d, required %0d", bcnt, W);
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL basic_sum_held: sum/cout changed during RUN, required stable");
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h96) begin
      errors++;
      $display("FAIL basic_after: done=%b busy=%b sum=%h, required 0 0 96", done, busy, sum);
    end
  endtask

  task automatic test_carry();
    logic [W-1:0] s;
    logic c;
    int lat, bcnt;
    bit to, held;
    do_op(8'hFF, 8'h01, 1'b0, s, c, lat, bcnt, to, held);
    checks++;
    if (to || s !== 8'h00 || c !== 1'b1) begin
      errors++;
      $display("FAIL carry_ripple: sum=%h cout=%b, required 00 1", s, c);
    end
    do_op(8'hFF, 8'hFF, 1'b1, s, c, lat, bcnt, to, held);
    checks++;
    if (to || s !== 8'hFF || c !== 1'b1) begin
      errors++;
      $display("FAIL carry_full: sum=%h cout=%b, required ff 1", s, c);
    end
  endtask

  task automatic test_ignore_start();
    int dcnt;
    logic [W-1:0] s;
    logic c;
    tick();
    a = 8'h10;
    b = 8'h20;
    cin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'hAA;
    b = 8'h55;
    cin = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    dcnt = 0;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (done) begin
        dcnt++;
        s = sum;
        c = cout;
      end
      tick();
    end
    checks++;
    if (dcnt != 1) begin
      errors++;
      $display("FAIL ignore_done_count: %0d, required 1", dcnt);
    end
    checks++;
    if (s !== 8'h30 || c !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result: sum=%h cout=%b, required 30 0", s, c);
    end
  endtask

  task automatic test_back_to_back();
    int idx[$];
    logic [W-1:0] ss[$];
    logic cc[$];
    int busy_bad;
    a = 8'h01;
    b = 8'h02;
    cin = 1'b0;
    start = 1'b1;
    tick();
    a = 8'h80;
    b = 8'h80;
    busy_bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy !== !done) busy_bad++;
      if (done) begin
        idx.push_back(i);
        ss.push_back(sum);
        cc.push_back(cout);
        if (idx.size() == 2) begin
          start = 1'b0;
          break;
        end
      end
      tick();
    end
    tick();
    tick();
    checks++;
    if (idx.size() != 2) begin
      errors++;
      $display("FAIL b2b_done_count: %0d, required 2", idx.size());
    end else begin
      checks++;
      if (idx[1] - idx[0] != W + 1) begin
        errors++;
        $display("FAIL b2b_spacing: %0d, required %0d", idx[1] - idx[0], W + 1);
      end
      checks++;
      if (ss[0] !== 8'h03 || cc[0] !== 1'b0 || ss[1] !== 8'h00 || cc[1] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_results: %h/%b then %h/%b, required 03/0 then 00/1",
                 ss[0], cc[0], ss[1], cc[1]);
      end
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL b2b_busy: %0d cycles with busy==done, required 0", busy_bad);
    end
  endtask

  task automatic test_reset_mid_run();
    int dcnt;
    logic [W-1:0] s;
    logic c;
    int lat, bcnt;
    bit to, held;
    a = 8'h7F;
    b = 8'h01;
    cin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0",
               busy, done, sum, cout);
    end
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dcnt++;
      tick();
    end
    checks++;
    if (dcnt != 0) begin
      errors++;
      $display("FAIL midrst_no_done: %0d pulses, required 0", dcnt);
    end
    do_op(8'h7F, 8'h01, 1'b0, s, c, lat, bcnt, to, held);
    checks++;
    if (to || s !== 8'h80 || c !== 1'b0) begin
      errors++;
      $display("FAIL midrst_rerun: sum=%h cout=%b, required 80 0", s, c);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv, s;
    logic cv, c;
    logic [W:0] exp;
    int lat, bcnt, ndone, nerr;
    bit to, held;
    ndone = 0;
    nerr = 0;
    for (int n = 0; n < 1000; n++) begin
      av = W'($urandom);
      bv = W'($urandom);
      cv = 1'($urandom);
      exp = model(av, bv, cv);
      do_op(av, bv, cv, s, c, lat, bcnt, to, held);
      if (!to) ndone++;
      checks++;
      if (to || {c, s} !== exp) begin
        errors++;
        nerr++;
        if (nerr <= 10)
          $display("FAIL random_op %0d: %h+%h+%b gave %b/%h timeout=%0d, required %b/%h",
                   n, av, bv, cv, c, s, to, exp[W], exp[W-1:0]);
      end
      if ($urandom_range(3) == 0) begin
        for (int k = 0; k < int'($urandom_range(3)); k++) tick();
      end
    end
    checks++;
    if (ndone != 1000) begin
      errors++;
      $display("FAIL random_done_count: %0d, required 1000", ndone);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
